// File: rtl/doc_pkg.sv
// ============================================================================
// Package  : doc_pkg
// Brief    : Document geometry, control characters and sender FSM encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package doc_pkg;

    localparam int DOC_ROWS   = 15;
    localparam int DOC_COLS   = 20;
    localparam int DOC_ADDR_W = 9;

    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_LF    = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SEND  = 3'd2,
        ST_CR    = 3'd3,
        ST_LF    = 3'd4,
        ST_DONE  = 3'd5
    } doc_state_e;

    // Empty cells are stored as NUL but must print as blanks.
    function automatic logic [7:0] map_cell(input logic [7:0] b);
        return (b == 8'h00) ? CHAR_SPACE : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_byte.sv
// ============================================================================
// Module   : uart_tx_byte
// Brief    : 8N1 byte serializer; accepts a new byte in the final stop cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       frame_done
);

    localparam int                  c_BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]          c_BIT_LAST  = 4'd9;

    logic [c_BAUD_W-1:0] r_baud;
    logic [3:0]          r_bit;
    logic [9:0]          r_shift;
    logic                r_busy;

    logic w_bit_end;
    logic w_last;
    logic w_accept;

    assign w_bit_end = (r_baud == c_BAUD_LAST);
    assign w_last    = r_busy && w_bit_end && (r_bit == c_BIT_LAST);
    // Accepting during the last stop cycle keeps consecutive frames gapless.
    assign w_accept  = load && (!r_busy || w_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '1;
            r_busy  <= 1'b0;
        end else if (w_accept) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= {1'b1, data, 1'b0};
            r_busy  <= 1'b1;
        end else if (r_busy) begin
            if (w_bit_end) begin
                r_baud  <= '0;
                r_shift <= {1'b1, r_shift[9:1]};
                if (r_bit == c_BIT_LAST) begin
                    r_busy <= 1'b0;
                    r_bit  <= '0;
                end else begin
                    r_bit <= r_bit + 4'd1;
                end
            end else begin
                r_baud <= r_baud + c_BAUD_W'(1);
            end
        end
    end

    assign tx         = r_shift[0];
    assign frame_done = w_last;

endmodule

`default_nettype wire

// File: rtl/doc_uart_sender.sv
// ============================================================================
// Module   : doc_uart_sender
// Brief    : Walks the document RAM row by row and streams it as 8N1 with CR LF.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module doc_uart_sender
    import doc_pkg::*;
#(
    parameter int CLK_HZ = 25_000_000,
    parameter int BAUD   = 115200,
    parameter int ROWS   = DOC_ROWS,
    parameter int COLS   = DOC_COLS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  rd_en,
    output logic [DOC_ADDR_W-1:0] rd_addr,
    input  logic [7:0]            rd_data,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);

    localparam int         c_CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam logic [4:0] c_COL_LAST     = 5'(COLS - 1);
    localparam logic [3:0] c_ROW_LAST     = 4'(ROWS - 1);

    doc_state_e r_state;
    doc_state_e w_state_nxt;
    logic [3:0] r_row;
    logic [3:0] w_row_nxt;
    logic [4:0] r_col;
    logic [4:0] w_col_nxt;
    logic       w_load;
    logic [7:0] w_data;
    logic       w_frame_done;

    uart_tx_byte #(
        .CLKS_PER_BIT(c_CLKS_PER_BIT)
    ) u_tx (
        .clk        (clk),
        .rst        (rst),
        .load       (w_load),
        .data       (w_data),
        .tx         (tx),
        .frame_done (w_frame_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_row   <= '0;
            r_col   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
            r_col   <= w_col_nxt;
        end
    end

    // CR and LF are loaded on the stop-bit cycle of the preceding frame so
    // they follow it without an idle gap; only character fetches add a cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_load      = 1'b0;
        w_data      = CHAR_SPACE;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_row_nxt   = '0;
                    w_col_nxt   = '0;
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_load      = 1'b1;
                w_data      = map_cell(rd_data);
                w_state_nxt = ST_SEND;
            end
            ST_SEND: begin
                if (w_frame_done) begin
                    if (r_col < c_COL_LAST) begin
                        w_col_nxt   = r_col + 5'd1;
                        w_state_nxt = ST_FETCH;
                    end else begin
                        w_load      = 1'b1;
                        w_data      = CHAR_CR;
                        w_state_nxt = ST_CR;
                    end
                end
            end
            ST_CR: begin
                if (w_frame_done) begin
                    w_load      = 1'b1;
                    w_data      = CHAR_LF;
                    w_state_nxt = ST_LF;
                end
            end
            ST_LF: begin
                if (w_frame_done) begin
                    if (r_row < c_ROW_LAST) begin
                        w_row_nxt   = r_row + 4'd1;
                        w_col_nxt   = '0;
                        w_state_nxt = ST_FETCH;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign rd_en   = (r_state == ST_FETCH);
    assign rd_addr = {r_row, r_col};
    assign busy    = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign done    = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_doc_uart_sender.sv
// ============================================================================
// Module   : tb_doc_uart_sender
// Brief    : Self-checking bench with RAM model, UART sampler and text model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_doc_uart_sender;

    localparam int CPB  = 4;
    localparam int ROWS = 2;
    localparam int COLS = 3;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic       rd_en;
    logic [8:0] rd_addr;
    logic [7:0] rd_data;
    logic       tx;
    logic       busy;
    logic       done;

    logic [7:0] ram [0:511];
    assign rd_data = ram[rd_addr];

    doc_uart_sender #(
        .CLK_HZ (400),
        .BAUD   (100),
        .ROWS   (ROWS),
        .COLS   (COLS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] rx_q[$];
    logic [8:0] addr_q[$];
    logic [7:0] exp_bytes[$];
    logic [8:0] exp_addr[$];
    int done_cnt, fe_cnt, rden_cnt, rden_bad, db_bad;

    bit         s_active  = 1'b0;
    int         s_off     = 0;
    logic [9:0] s_bits    = '0;
    logic       prev_busy = 1'b0;
    logic       prev_rden = 1'b0;

    // UART sampler (mid-bit) and bus monitors.
    always @(negedge clk) begin
        if (rst) begin
            s_active = 1'b0;
        end else begin
            if (!s_active) begin
                if (tx === 1'b0) begin
                    s_active = 1'b1;
                    s_off    = 0;
                end
            end else begin
                s_off++;
                if (s_off % CPB == CPB / 2) s_bits = {tx, s_bits[9:1]};
                if (s_off == 9 * CPB + CPB / 2) begin
                    if (s_bits[0] !== 1'b0 || s_bits[9] !== 1'b1) fe_cnt++;
                    rx_q.push_back(s_bits[8:1]);
                    s_active = 1'b0;
                end
            end
            if (rd_en) begin
                addr_q.push_back(rd_addr);
                rden_cnt++;
                if (prev_rden || tx !== 1'b1) rden_bad++;
            end
            if (done) begin
                done_cnt++;
                if (busy || !prev_busy) db_bad++;
            end
        end
        prev_rden = rd_en;
        prev_busy = busy;
    end

    task automatic clear_logs();
        rx_q.delete();
        addr_q.delete();
        done_cnt = 0; fe_cnt = 0; rden_cnt = 0; rden_bad = 0; db_bad = 0;
    endtask

    task automatic fill_ram(input int mode);
        for (int i = 0; i < 512; i++) begin
            if (mode == 1) ram[i] = 8'h00;
            else if ($urandom_range(0, 3) == 0) ram[i] = 8'h00;
            else ram[i] = 8'($urandom_range(33, 126));
        end
        if (mode == 0) begin
            ram[0]  = 8'h41; ram[1]  = 8'h42; ram[2]  = 8'h43;
            ram[32] = 8'h78; ram[33] = 8'h79; ram[34] = 8'h7A;
        end
    endtask

    // Expected stream: every cell of every row (blank for empty), then CR LF.
    task automatic model_build();
        logic [8:0] a;
        exp_bytes.delete();
        exp_addr.delete();
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                a = 9'(r * 32 + c);
                exp_addr.push_back(a);
                exp_bytes.push_back(ram[a] == 8'h00 ? 8'h20 : ram[a]);
            end
            exp_bytes.push_back(8'h0D);
            exp_bytes.push_back(8'h0A);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done_cnt == 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (done_cnt == 0) $display("FAIL %s timeout: no done after %0d cycles, required a done pulse", name, n);
        else n_pass++;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (rd_addr !== 9'h000) $display("FAIL reset rd_addr: got %03h required 000", rd_addr);
        else n_pass++;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            n_checks++;
            if ({tx, busy, done, rd_en} !== 4'b1000)
                $display("FAIL idle cycle %0d {tx,busy,done,rd_en}: got %b required 1000", i, {tx, busy, done, rd_en});
            else n_pass++;
        end
    endtask

    task automatic test_stream(input string name, input int mode);
        fill_ram(mode);
        model_build();
        clear_logs();
        pulse_start();
        wait_done(name);
        n_checks++;
        if (rx_q.size() != exp_bytes.size())
            $display("FAIL %s byte count: got %0d required %0d", name, rx_q.size(), exp_bytes.size());
        else n_pass++;
        for (int i = 0; i < exp_bytes.size(); i++) begin
            n_checks++;
            if (i >= rx_q.size() || rx_q[i] !== exp_bytes[i])
                $display("FAIL %s byte %0d: got %02h required %02h", name, i,
                         (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_bytes[i]);
            else n_pass++;
        end
        for (int i = 0; i < exp_addr.size(); i++) begin
            n_checks++;
            if (i >= addr_q.size() || addr_q[i] !== exp_addr[i])
                $display("FAIL %s rd_addr %0d: got %03h required %03h", name, i,
                         (i < addr_q.size()) ? addr_q[i] : 9'hxxx, exp_addr[i]);
            else n_pass++;
        end
        n_checks++;
        if (rden_cnt != ROWS * COLS || rden_bad != 0)
            $display("FAIL %s rd_en: got %0d pulses (%0d bad) required %0d single pulses with tx high",
                     name, rden_cnt, rden_bad, ROWS * COLS);
        else n_pass++;
        n_checks++;
        if (done_cnt != 1 || db_bad != 0 || fe_cnt != 0)
            $display("FAIL %s done/framing: got %0d done, %0d busy errors, %0d framing errors required 1,0,0",
                     name, done_cnt, db_bad, fe_cnt);
        else n_pass++;
    endtask

    task automatic test_single_frame();
        logic [9:0] frame;
        bit         ok;
        int         n = 0;
        fill_ram(2);
        ram[0] = 8'h55;
        frame  = {1'b1, 8'h55, 1'b0};
        clear_logs();
        pulse_start();
        while (rd_en !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (rd_en !== 1'b1 || tx !== 1'b1) $display("FAIL frame fetch: rd_en=%b tx=%b required 1 1", rd_en, tx);
        else n_pass++;
        for (int k = 0; k < 10; k++) begin
            ok = 1'b1;
            repeat (CPB) begin
                @(negedge clk);
                if (tx !== frame[k]) ok = 1'b0;
            end
            n_checks++;
            if (!ok) $display("FAIL frame bit %0d: tx got %b (last) required %b for %0d cycles", k, tx, frame[k], CPB);
            else n_pass++;
        end
        wait_done("single_frame");
    endtask

    task automatic test_start_while_busy();
        int  n = 0;
        bit  idle_ok = 1'b1;
        fill_ram(0);
        model_build();
        clear_logs();
        pulse_start();
        repeat (60) @(negedge clk);
        pulse_start();
        repeat (130) @(negedge clk);
        pulse_start();
        while (done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || rd_en !== 1'b0) idle_ok = 1'b0;
        end
        n_checks++;
        if (!idle_ok || done_cnt != 1)
            $display("FAIL busy_start restart: got %0d done pulses, idle_ok=%b required 1 and idle", done_cnt, idle_ok);
        else n_pass++;
        n_checks++;
        if (rx_q.size() != exp_bytes.size())
            $display("FAIL busy_start byte count: got %0d required %0d", rx_q.size(), exp_bytes.size());
        else n_pass++;
        for (int i = 0; i < exp_bytes.size(); i++) begin
            n_checks++;
            if (i >= rx_q.size() || rx_q[i] !== exp_bytes[i])
                $display("FAIL busy_start byte %0d: got %02h required %02h", i,
                         (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_bytes[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        bit quiet = 1'b1;
        fill_ram(0);
        model_build();
        clear_logs();
        pulse_start();
        while (rx_q.size() < 3 && n < 600) begin
            @(negedge clk);
            n++;
        end
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({tx, busy, done} !== 3'b100)
            $display("FAIL reset_mid {tx,busy,done}: got %b required 100", {tx, busy, done});
        else n_pass++;
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || tx !== 1'b1) quiet = 1'b0;
        end
        n_checks++;
        if (done_cnt != 0 || !quiet)
            $display("FAIL reset_mid aftermath: got %0d done pulses, quiet=%b required 0 and quiet", done_cnt, quiet);
        else n_pass++;
        clear_logs();
        pulse_start();
        wait_done("reset_mid_rerun");
        n_checks++;
        if (addr_q.size() == 0 || addr_q[0] !== 9'h000)
            $display("FAIL reset_mid first rd_addr: got %03h required 000", (addr_q.size() > 0) ? addr_q[0] : 9'hxxx);
        else n_pass++;
        for (int i = 0; i < exp_bytes.size(); i++) begin
            n_checks++;
            if (i >= rx_q.size() || rx_q[i] !== exp_bytes[i])
                $display("FAIL reset_mid byte %0d: got %02h required %02h", i,
                         (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_bytes[i]);
            else n_pass++;
        end
    endtask

    initial begin
        fill_ram(1);
        test_reset();
        test_stream("text", 0);
        test_stream("empty", 1);
        for (int i = 0; i < 3; i++) test_stream("random", 2);
        test_single_frame();
        test_start_while_busy();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
